// File: rtl/rv_wb_pkg.sv
// Shared Wishbone arbiter types and width helpers.
// Used by the arbiter top and by its priority encoder.
package rv_wb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int WB_BYTE_W      = 8;
  localparam int WB_ADDR_W_DEF  = 32;
  localparam int WB_DATA_W_DEF  = 32;

  function automatic int sel_width(input int data_w);
    return data_w / WB_BYTE_W;
  endfunction

  // A disabled timeout (0) still gets a 1-bit counter so widths stay legal.
  function automatic int tmo_cnt_width(input int timeout_cycles);
    return (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rv_arb_prio_enc.sv
// Rotating priority encoder: picks the first set request at or after start,
// wrapping modulo N. start=0 gives plain lowest-index-wins priority.
module rv_arb_prio_enc
  import rv_wb_pkg::*;
#(
  parameter  int N     = 2,
  localparam int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] index,
  output logic             valid
);

  int               pos;
  logic [IDX_W-1:0] pos_idx;

  always_comb begin
    grant   = '0;
    index   = '0;
    valid   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int i = 0; i < N; i++) begin
      pos = int'(start) + i;
      if (pos >= N) pos = pos - N;
      pos_idx = IDX_W'(pos);
      if (!valid && req[pos_idx]) begin
        valid          = 1'b1;
        grant[pos_idx] = 1'b1;
        index          = pos_idx;
      end
    end
  end

endmodule

// File: rtl/rv_wb_arbiter.sv
// N-master Wishbone classic arbiter: one slave bus, grant held for the whole
// master cyc window, fixed or round-robin priority, optional stall timeout.
module rv_wb_arbiter
  import rv_wb_pkg::*;
#(
  parameter  int CHANNELS       = 2,
  parameter  int ADDR_W         = WB_ADDR_W_DEF,
  parameter  int DATA_W         = WB_DATA_W_DEF,
  parameter  int ROUND_ROBIN    = 0,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int SEL_W          = sel_width(DATA_W)
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic [CHANNELS*ADDR_W-1:0]   i_m_adr,
  input  logic [CHANNELS*DATA_W-1:0]   i_m_dat,
  input  logic [CHANNELS-1:0]          i_m_we,
  input  logic [CHANNELS*SEL_W-1:0]    i_m_sel,
  input  logic [CHANNELS-1:0]          i_m_cyc,
  input  logic [CHANNELS-1:0]          i_m_stb,
  output logic [DATA_W-1:0]            o_m_dat,
  output logic [CHANNELS-1:0]          o_m_ack,
  output logic [CHANNELS-1:0]          o_m_err,
  output logic [ADDR_W-1:0]            o_wb_adr,
  output logic [DATA_W-1:0]            o_wb_dat,
  output logic                         o_wb_we,
  output logic [SEL_W-1:0]             o_wb_sel,
  output logic                         o_wb_cyc,
  output logic                         o_wb_stb,
  input  logic [DATA_W-1:0]            i_wb_dat,
  input  logic                         i_wb_ack,
  input  logic                         i_wb_err,
  output logic [CHANNELS-1:0]          o_grant,
  output logic                         o_busy
);

  localparam int IDX_W = idx_width(CHANNELS);
  localparam int CNT_W = tmo_cnt_width(TIMEOUT_CYCLES);

  arb_state_t          state_q, state_d;
  logic [CHANNELS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d, last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [CHANNELS-1:0] req, enc_grant;
  logic [IDX_W-1:0]    enc_index, start;
  logic                enc_valid, busy, g_cyc, g_stb, timeout;

  assign req   = i_m_cyc & i_m_stb;
  assign start = (ROUND_ROBIN != 0) ?
                 ((last_q == IDX_W'(CHANNELS - 1)) ? '0 : last_q + 1'b1) : '0;

  rv_arb_prio_enc #(.N(CHANNELS)) u_prio_enc (
    .req   (req),
    .start (start),
    .grant (enc_grant),
    .index (enc_index),
    .valid (enc_valid)
  );

  assign busy  = (state_q == ARB_BUSY);
  assign g_cyc = i_m_cyc[gidx_q];
  assign g_stb = i_m_stb[gidx_q];

  // A slave ack/err in the limit cycle wins over the timeout.
  assign timeout = (TIMEOUT_CYCLES != 0) && busy && g_cyc && g_stb &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES)) && !i_wb_ack && !i_wb_err;

  // Handshake: a beat completes in the cycle the slave returns ack or err
  // while stb is high; the granted master owns the bus until it drops cyc.
  always_comb begin
    o_wb_adr = '0;
    o_wb_dat = '0;
    o_wb_we  = 1'b0;
    o_wb_sel = '0;
    o_wb_cyc = 1'b0;
    o_wb_stb = 1'b0;
    o_m_dat  = '0;
    o_m_ack  = '0;
    o_m_err  = '0;
    if (busy) begin
      o_wb_adr = i_m_adr[gidx_q*ADDR_W +: ADDR_W];
      o_wb_dat = i_m_dat[gidx_q*DATA_W +: DATA_W];
      o_wb_we  = i_m_we[gidx_q];
      o_wb_sel = i_m_sel[gidx_q*SEL_W +: SEL_W];
      o_wb_cyc = g_cyc & ~timeout;
      o_wb_stb = g_cyc & g_stb & ~timeout;
      o_m_dat  = i_wb_dat;
      o_m_ack  = grant_q & {CHANNELS{i_wb_ack & ~i_wb_err}};
      o_m_err  = grant_q & {CHANNELS{i_wb_err | timeout}};
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    cnt_d   = '0;
    case (state_q)
      ARB_IDLE: begin
        if (enc_valid) begin
          state_d = ARB_BUSY;
          grant_d = enc_grant;
          gidx_d  = enc_index;
          last_d  = enc_index;
        end
      end
      ARB_BUSY: begin
        if (!g_cyc || timeout) begin
          state_d = ARB_IDLE;
          grant_d = '0;
        end else if ((TIMEOUT_CYCLES != 0) && g_stb && !i_wb_ack && !i_wb_err &&
                     (cnt_q != CNT_W'(TIMEOUT_CYCLES))) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IDX_W'(CHANNELS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_grant = grant_q;
  assign o_busy  = busy;

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// Directed bench: a 2-channel fixed-priority arbiter with a 4-cycle timeout
// and a 3-channel round-robin arbiter with the timeout disabled.
module tb_rv_wb_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // fixed-priority instance, CHANNELS=2, TIMEOUT_CYCLES=4
  logic [2*AW-1:0] f_m_adr;
  logic [2*DW-1:0] f_m_dat;
  logic [1:0]      f_m_we, f_m_cyc, f_m_stb, f_m_ack, f_m_err, f_grant;
  logic [2*SW-1:0] f_m_sel;
  logic [DW-1:0]   f_m_dat_o, f_wb_dat, f_wb_dat_i;
  logic [AW-1:0]   f_wb_adr;
  logic [SW-1:0]   f_wb_sel;
  logic            f_wb_we, f_wb_cyc, f_wb_stb, f_wb_ack, f_wb_err, f_busy;

  // round-robin instance, CHANNELS=3, timeout disabled
  logic [3*AW-1:0] r_m_adr;
  logic [3*DW-1:0] r_m_dat;
  logic [2:0]      r_m_we, r_m_cyc, r_m_stb, r_m_ack, r_m_err, r_grant;
  logic [3*SW-1:0] r_m_sel;
  logic [DW-1:0]   r_m_dat_o, r_wb_dat, r_wb_dat_i;
  logic [AW-1:0]   r_wb_adr;
  logic [SW-1:0]   r_wb_sel;
  logic            r_wb_we, r_wb_cyc, r_wb_stb, r_wb_ack, r_wb_err, r_busy;

  rv_wb_arbiter #(.CHANNELS(2), .ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(4)) u_fix (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_m_adr(f_m_adr), .i_m_dat(f_m_dat), .i_m_we(f_m_we), .i_m_sel(f_m_sel),
    .i_m_cyc(f_m_cyc), .i_m_stb(f_m_stb),
    .o_m_dat(f_m_dat_o), .o_m_ack(f_m_ack), .o_m_err(f_m_err),
    .o_wb_adr(f_wb_adr), .o_wb_dat(f_wb_dat), .o_wb_we(f_wb_we), .o_wb_sel(f_wb_sel),
    .o_wb_cyc(f_wb_cyc), .o_wb_stb(f_wb_stb),
    .i_wb_dat(f_wb_dat_i), .i_wb_ack(f_wb_ack), .i_wb_err(f_wb_err),
    .o_grant(f_grant), .o_busy(f_busy)
  );

  rv_wb_arbiter #(.CHANNELS(3), .ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(0)) u_rr (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_m_adr(r_m_adr), .i_m_dat(r_m_dat), .i_m_we(r_m_we), .i_m_sel(r_m_sel),
    .i_m_cyc(r_m_cyc), .i_m_stb(r_m_stb),
    .o_m_dat(r_m_dat_o), .o_m_ack(r_m_ack), .o_m_err(r_m_err),
    .o_wb_adr(r_wb_adr), .o_wb_dat(r_wb_dat), .o_wb_we(r_wb_we), .o_wb_sel(r_wb_sel),
    .o_wb_cyc(r_wb_cyc), .o_wb_stb(r_wb_stb),
    .i_wb_dat(r_wb_dat_i), .i_wb_ack(r_wb_ack), .i_wb_err(r_wb_err),
    .o_grant(r_grant), .o_busy(r_busy)
  );

  task automatic clear_inputs();
    f_m_adr = '0; f_m_dat = '0; f_m_we = '0; f_m_sel = '0; f_m_cyc = '0; f_m_stb = '0;
    f_wb_dat_i = '0; f_wb_ack = 1'b0; f_wb_err = 1'b0;
    r_m_adr = '0; r_m_dat = '0; r_m_we = '0; r_m_sel = '0; r_m_cyc = '0; r_m_stb = '0;
    r_wb_dat_i = '0; r_wb_ack = 1'b0; r_wb_err = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    f_m_cyc = 2'b11; f_m_stb = 2'b11; f_wb_ack = 1'b1; f_wb_dat_i = 32'h1234_5678;
    r_m_cyc = 3'b111; r_m_stb = 3'b111; r_wb_ack = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (f_grant !== 2'b00) begin errors++; $display("FAIL rst_f_grant: got %b want 00", f_grant); end
    checks++; if (f_busy !== 1'b0) begin errors++; $display("FAIL rst_f_busy: got %b want 0", f_busy); end
    checks++; if (f_wb_cyc !== 1'b0) begin errors++; $display("FAIL rst_f_cyc: got %b want 0", f_wb_cyc); end
    checks++; if (f_m_ack !== 2'b00) begin errors++; $display("FAIL rst_f_ack: got %b want 00", f_m_ack); end
    checks++; if (f_m_dat_o !== 32'h0) begin errors++; $display("FAIL rst_f_mdat: got %h want 0", f_m_dat_o); end
    checks++; if (r_grant !== 3'b000) begin errors++; $display("FAIL rst_r_grant: got %b want 000", r_grant); end
    clear_inputs();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fixed_priority();
    f_m_adr = {32'h200, 32'h100}; f_m_dat = {32'hBBBB_0001, 32'hAAAA_0000};
    f_m_we = 2'b01; f_m_sel = {4'h3, 4'hF}; f_m_cyc = 2'b11; f_m_stb = 2'b11;
    @(negedge clk);
    checks++; if (f_wb_cyc !== 1'b0) begin errors++; $display("FAIL fp_idle_cyc: got %b want 0", f_wb_cyc); end
    @(posedge clk); #1 f_wb_ack = 1'b1;
    @(negedge clk);
    checks++; if (f_grant !== 2'b01) begin errors++; $display("FAIL fp_grant0: got %b want 01", f_grant); end
    checks++; if (f_wb_adr !== 32'h100) begin errors++; $display("FAIL fp_adr0: got %h want 100", f_wb_adr); end
    checks++; if (f_wb_dat !== 32'hAAAA_0000) begin errors++; $display("FAIL fp_dat0: got %h want aaaa0000", f_wb_dat); end
    checks++; if ({f_wb_we, f_wb_sel} !== 5'b1_1111) begin errors++; $display("FAIL fp_we_sel0: got %b want 11111", {f_wb_we, f_wb_sel}); end
    checks++; if (f_m_ack !== 2'b01) begin errors++; $display("FAIL fp_ack0: got %b want 01", f_m_ack); end
    @(posedge clk); #1 f_wb_ack = 1'b0; f_m_cyc[0] = 1'b0; f_m_stb[0] = 1'b0;
    @(negedge clk);
    checks++; if ({f_busy, f_wb_cyc} !== 2'b10) begin errors++; $display("FAIL fp_drop: got busy,cyc=%b want 10", {f_busy, f_wb_cyc}); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if ({f_busy, f_grant} !== 3'b000) begin errors++; $display("FAIL fp_gap: got busy,grant=%b want 000", {f_busy, f_grant}); end
    checks++; if (f_wb_adr !== 32'h0) begin errors++; $display("FAIL fp_gap_adr: got %h want 0", f_wb_adr); end
    @(posedge clk); #1 f_wb_ack = 1'b1;
    @(negedge clk);
    checks++; if (f_grant !== 2'b10) begin errors++; $display("FAIL fp_grant1: got %b want 10", f_grant); end
    checks++; if (f_wb_adr !== 32'h200) begin errors++; $display("FAIL fp_adr1: got %h want 200", f_wb_adr); end
    checks++; if ({f_wb_we, f_wb_sel} !== 5'b0_0011) begin errors++; $display("FAIL fp_we_sel1: got %b want 00011", {f_wb_we, f_wb_sel}); end
    checks++; if (f_m_ack !== 2'b10) begin errors++; $display("FAIL fp_ack1: got %b want 10", f_m_ack); end
    @(posedge clk); #1 clear_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_locked();
    f_m_adr = {32'h200, 32'h100}; f_m_cyc = 2'b10; f_m_stb = 2'b10;
    @(posedge clk); #1 f_m_cyc = 2'b11; f_m_stb = 2'b11;
    for (int b = 0; b < 3; b++) begin
      f_wb_ack = 1'b1;
      @(negedge clk);
      checks++; if ({f_grant, f_m_ack} !== 4'b1010) begin errors++; $display("FAIL lock_beat%0d: got grant,ack=%b want 1010", b, {f_grant, f_m_ack}); end
      @(posedge clk); #1;
    end
    f_wb_ack = 1'b0; f_m_cyc[1] = 1'b0; f_m_stb[1] = 1'b0;
    @(negedge clk);
    checks++; if ({f_busy, f_grant} !== 3'b110) begin errors++; $display("FAIL lock_release: got busy,grant=%b want 110", {f_busy, f_grant}); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (f_grant !== 2'b00) begin errors++; $display("FAIL lock_gap: got %b want 00", f_grant); end
    @(posedge clk); #1 f_wb_ack = 1'b1;
    @(negedge clk);
    checks++; if ({f_grant, f_m_ack} !== 4'b0101) begin errors++; $display("FAIL lock_ch0: got grant,ack=%b want 0101", {f_grant, f_m_ack}); end
    checks++; if (f_wb_adr !== 32'h100) begin errors++; $display("FAIL lock_ch0_adr: got %h want 100", f_wb_adr); end
    @(posedge clk); #1 clear_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    f_m_adr = {32'h200, 32'h100}; f_m_cyc = 2'b11; f_m_stb = 2'b11;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if ({f_m_err, f_wb_cyc} !== 3'b001) begin errors++; $display("FAIL tmo_stall%0d: got err,cyc=%b want 001", i, {f_m_err, f_wb_cyc}); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (f_m_err !== 2'b01) begin errors++; $display("FAIL tmo_err: got %b want 01", f_m_err); end
    checks++; if ({f_wb_cyc, f_wb_stb} !== 2'b00) begin errors++; $display("FAIL tmo_cyc: got cyc,stb=%b want 00", {f_wb_cyc, f_wb_stb}); end
    @(posedge clk); #1 f_m_cyc[0] = 1'b0; f_m_stb[0] = 1'b0;
    @(negedge clk);
    checks++; if ({f_busy, f_m_err} !== 3'b000) begin errors++; $display("FAIL tmo_idle: got busy,err=%b want 000", {f_busy, f_m_err}); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (f_grant !== 2'b10) begin errors++; $display("FAIL tmo_next: got %b want 10", f_grant); end
    repeat (4) @(posedge clk);
    #1 f_wb_ack = 1'b1;
    @(negedge clk);
    checks++; if ({f_m_ack, f_m_err} !== 4'b1000) begin errors++; $display("FAIL tmo_ack_wins: got ack,err=%b want 1000", {f_m_ack, f_m_err}); end
    checks++; if (f_wb_cyc !== 1'b1) begin errors++; $display("FAIL tmo_ack_cyc: got %b want 1", f_wb_cyc); end
    @(posedge clk); #1 clear_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_err_ack();
    f_m_adr = {32'h0, 32'h300}; f_m_cyc = 2'b01; f_m_stb = 2'b01;
    @(posedge clk); #1 f_wb_ack = 1'b1; f_wb_err = 1'b1; f_wb_dat_i = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if ({f_m_err, f_m_ack} !== 4'b0100) begin errors++; $display("FAIL errack_both: got err,ack=%b want 0100", {f_m_err, f_m_ack}); end
    @(posedge clk); #1 f_wb_err = 1'b0;
    @(negedge clk);
    checks++; if ({f_m_err, f_m_ack} !== 4'b0001) begin errors++; $display("FAIL errack_ack: got err,ack=%b want 0001", {f_m_err, f_m_ack}); end
    checks++; if (f_m_dat_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL errack_rdata: got %h want deadbeef", f_m_dat_o); end
    @(posedge clk); #1 clear_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic [2:0]    exp_g;
    logic [AW-1:0] exp_a;
    int            g;
    r_m_adr = {32'h2C, 32'h1C, 32'h0C}; r_m_cyc = 3'b111; r_m_stb = 3'b111;
    for (int k = 0; k < 6; k++) begin
      g = k % 3;
      exp_g = 3'b001 << g;
      exp_a = 32'h0C + 32'h10 * g;
      @(posedge clk); #1 r_wb_ack = 1'b1;
      @(negedge clk);
      checks++; if (r_grant !== exp_g) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", k, r_grant, exp_g); end
      checks++; if ({r_m_ack, r_wb_adr} !== {exp_g, exp_a}) begin errors++; $display("FAIL rr_ack_adr%0d: got %b/%h want %b/%h", k, r_m_ack, r_wb_adr, exp_g, exp_a); end
      @(posedge clk); #1 r_wb_ack = 1'b0; r_m_cyc[g] = 1'b0; r_m_stb[g] = 1'b0;
      @(posedge clk); #1 r_m_cyc[g] = 1'b1; r_m_stb[g] = 1'b1;
    end
    clear_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_busy();
    r_m_adr = {32'h2C, 32'h1C, 32'h0C}; r_m_cyc = 3'b001; r_m_stb = 3'b001;
    @(posedge clk); #1 r_m_cyc = 3'b111; r_m_stb = 3'b111; r_wb_ack = 1'b1; r_wb_dat_i = 32'hCAFE_F00D;
    @(negedge clk);
    checks++; if (r_m_ack !== 3'b001) begin errors++; $display("FAIL mid_pre_ack: got %b want 001", r_m_ack); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({r_busy, r_grant} !== 4'b0000) begin errors++; $display("FAIL mid_rst_state: got busy,grant=%b want 0000", {r_busy, r_grant}); end
    checks++; if ({r_wb_cyc, r_wb_stb, r_m_ack} !== 5'b0) begin errors++; $display("FAIL mid_rst_bus: got cyc,stb,ack=%b want 00000", {r_wb_cyc, r_wb_stb, r_m_ack}); end
    checks++; if ({r_wb_adr, r_m_dat_o} !== 64'h0) begin errors++; $display("FAIL mid_rst_data: got adr=%h mdat=%h want 0", r_wb_adr, r_m_dat_o); end
    r_wb_ack = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (r_grant !== 3'b001) begin errors++; $display("FAIL mid_rr_restart: got %b want 001", r_grant); end
    @(posedge clk); #1 clear_inputs();
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_locked();
    test_timeout();
    test_err_ack();
    test_round_robin();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv_wb_arbiter.md
Name: rv_wb_arbiter

Overview:
- Parametrised N-master Wishbone classic arbiter that replaces the core's fixed fetch/data address mux.
- Grants one slave bus to one master at a time and holds the grant for the master's whole cyc window.
- Provides fixed-priority or round-robin arbitration and a bus-timeout error response.
- Sits between the core's fetch/data/debug masters and the system Wishbone interconnect.

Parameters:
CHANNELS, 2, number of masters (2..8); channel 0 is highest priority in fixed mode
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8); SEL_W = DATA_W/8
ROUND_ROBIN, 0, 0 = fixed priority, 1 = round-robin
TIMEOUT_CYCLES, 255, stalled-strobe cycles before error; 0 disables the timeout

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_m_adr  in  CHANNELS*ADDR_W  master addresses, channel k at [k*ADDR_W +: ADDR_W]
i_m_dat  in  CHANNELS*DATA_W  master write data
i_m_we  in  CHANNELS  master write enables
i_m_sel  in  CHANNELS*SEL_W  master byte selects
i_m_cyc  in  CHANNELS  master cycle requests
i_m_stb  in  CHANNELS  master strobes
o_m_dat  out  DATA_W  read data, broadcast to all masters
o_m_ack  out  CHANNELS  per-master ack
o_m_err  out  CHANNELS  per-master error (slave err or timeout)
o_wb_adr  out  ADDR_W  slave address
o_wb_dat  out  DATA_W  slave write data
o_wb_we  out  1  slave write enable
o_wb_sel  out  SEL_W  slave byte select
o_wb_cyc  out  1  slave cycle
o_wb_stb  out  1  slave strobe
i_wb_dat  in  DATA_W  slave read data
i_wb_ack  in  1  slave ack
i_wb_err  in  1  slave error
o_grant  out  CHANNELS  one-hot registered grant
o_busy  out  1  high in BUSY

Behaviour:
- Reset (async, i_reset_n=0):
  - state=IDLE, grant=0, timeout counter=0.
  - RR pointer last=CHANNELS-1, so channel 0 wins first.
  - All outputs are 0, including while a transfer is in flight; no ack or err is produced.
- States:
  - IDLE: request vector req = i_m_cyc & i_m_stb. If req≠0, register the one-hot grant and go to BUSY on the next edge. Slave bus is idle: cyc=stb=we=0, adr/dat/sel=0.
  - Fixed priority: lowest requesting index wins.
  - Round-robin: first requesting index scanning from last+1 upward, wrapping modulo CHANNELS; on grant, last is set to the granted index.
  - BUSY: slave adr/dat/we/sel/cyc/stb driven combinationally from the granted channel. i_wb_ack/i_wb_err are routed combinationally to that channel's o_m_ack/o_m_err only. All other channels' ack/err stay 0.
- Grant hold and release:
  - The grant holds while the granted i_m_cyc=1, so multiple stb beats are allowed (locked RMW).
  - When the granted i_m_cyc=0, go to IDLE on the next edge.
  - If the master drops cyc in the same cycle as ack, the ack is still delivered that cycle.
- Arbitration latency: one cycle from request to slave cyc, plus one IDLE cycle between consecutive grants. Back-to-back masters therefore see a minimum 1-cycle bus gap.
- Timeout counter (TIMEOUT_CYCLES>0):
  - Counter width is clog2(TIMEOUT_CYCLES+1).
  - It increments in BUSY while o_wb_stb=1 and ack=err=0, and clears on ack, err or stb=0.
  - When the count equals TIMEOUT_CYCLES:
    - o_m_err pulses to the granted channel for 1 cycle.
    - o_wb_cyc and o_wb_stb are forced to 0 that cycle.
    - State goes to IDLE.
  - If i_wb_ack or i_wb_err arrives in the timeout cycle, the slave response wins: normal ack/err, no timeout err.
- Simultaneous ack and err from the slave: err takes precedence; o_m_ack is 0.
- Non-granted masters see no response and simply wait. Requests withdrawn while in IDLE are not granted.
- o_grant and o_busy are registered state outputs.

Decomposition:
- Package rv_wb_pkg:
  - arbiter state enum {ARB_IDLE, ARB_BUSY}
  - localparam helpers for SEL_W and counter width
  - shared Wishbone signal-width constants
- One sub-module rv_arb_prio_enc:
  - parametrised rotating priority encoder
  - inputs: req vector, start index
  - outputs: one-hot grant, encoded index, valid
  - fixed mode ties start=0

Test Plan:
- CHANNELS=2 fixed: ch0 and ch1 request together, adr 0x100/0x200 -> o_grant=01, o_wb_adr=0x100, ack to ch0 only; after ch0 drops cyc, one IDLE cycle, then grant=10 and adr=0x200.
- CHANNELS=3, ROUND_ROBIN=1: all three request continuously, each releasing after one ack -> grant sequence 0,1,2,0,1,2.
- Locked cycle: ch1 holds cyc over 3 stb beats while ch0 requests -> ch0 waits; 3 acks reach ch1; ch0 is granted 2 cycles after ch1 drops cyc.
- TIMEOUT_CYCLES=4: slave never acks -> o_m_err pulses on the granted channel after 4 stalled cycles, o_wb_cyc=0 that cycle, next master granted. Repeat with ack on cycle 4 -> ack delivered, no err.
- Slave err with ack simultaneously -> o_m_err=1, o_m_ack=0 on the granted channel. Read data 0xDEADBEEF appears on o_m_dat with ack.
- Assert i_reset_n=0 mid-BUSY -> all outputs 0 immediately. After release, ch0 wins in RR mode despite an earlier last-grant value.
